// File: rtl/bus_master.sv
`timescale 1ns/1ps
// bus_master: single-transfer 68000 bus initiator with BR/BG/BGACK arbitration.
// Define BUS_TIMEOUT_EN to build the WAIT_ACK watchdog (TIMEOUT_CYCLES clocks).
module bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        WE,
    input  logic        BYTE,
    input  logic [23:0] ADDR_IN,
    input  logic [15:0] WDATA,
    output logic [15:0] RDATA,
    output logic        DONE,
    output logic        ERR,
    output logic        BUSY,
    output logic        BR,
    output logic        BGACK,
    input  logic        BG,
    input  logic        AS_IN,
    input  logic        DTACK,
    input  logic        BERR,
    output logic        AS,
    output logic        UDS,
    output logic        LDS,
    output logic        RW,
    output logic [22:0] A_OUT,
    output logic [15:0] D_OUT,
    input  logic [15:0] D_IN,
    output logic        BUS_OE,
    output logic        D_OE
);

    typedef enum logic [2:0] {
        IDLE, BUSREQ, GRANT_WAIT, DRIVE, STROBE, WAIT_ACK, TERM, RELEASE
    } state_t;

    state_t state, state_n;

    logic [1:0] bg_sync, as_sync, dtack_sync, berr_sync;
    logic       bg_s, as_s, dtack_s, berr_s;

    logic        we_q, we_n;
    logic        byte_q, byte_n;
    logic [23:0] addr_q, addr_n;
    logic [15:0] wdata_q, wdata_n;
    logic        err_flag, err_flag_n;

    logic [15:0] rdata_n, d_out_n;
    logic [22:0] a_out_n;
    logic        done_n, err_n, busy_n, br_n, bgack_n;
    logic        as_n, uds_n, lds_n, rw_n, bus_oe_n, d_oe_n;

    logic tmo_hit, release_ok;

    // Bus-side handshakes are asynchronous to CLK; the FSM sees only these.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bg_sync    <= 2'b11;
            as_sync    <= 2'b11;
            dtack_sync <= 2'b11;
            berr_sync  <= 2'b11;
        end else begin
            bg_sync    <= {bg_sync[0], BG};
            as_sync    <= {as_sync[0], AS_IN};
            dtack_sync <= {dtack_sync[0], DTACK};
            berr_sync  <= {berr_sync[0], BERR};
        end
    end

    assign bg_s    = bg_sync[1];
    assign as_s    = as_sync[1];
    assign dtack_s = dtack_sync[1];
    assign berr_s  = berr_sync[1];

`ifdef BUS_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       timed_out;

    // A timed-out slave may never negate DTACK, so RELEASE only waits on BERR.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tmo_cnt   <= 8'd0;
            timed_out <= 1'b0;
        end else begin
            tmo_cnt <= (state == WAIT_ACK) ? tmo_cnt + 8'd1 : 8'd0;
            if (state == STROBE)
                timed_out <= 1'b0;
            else if (state == WAIT_ACK && berr_s && dtack_s && tmo_hit)
                timed_out <= 1'b1;
        end
    end

    assign tmo_hit    = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign release_ok = berr_s && (dtack_s || timed_out);
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT_CYCLES);
    assign tmo_hit        = 1'b0;
    assign release_ok     = berr_s && dtack_s;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            byte_q   <= 1'b0;
            addr_q   <= 24'd0;
            wdata_q  <= 16'd0;
            err_flag <= 1'b0;
            RDATA    <= 16'd0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            BUSY     <= 1'b0;
            BR       <= 1'b1;
            BGACK    <= 1'b1;
            AS       <= 1'b1;
            UDS      <= 1'b1;
            LDS      <= 1'b1;
            RW       <= 1'b1;
            A_OUT    <= 23'd0;
            D_OUT    <= 16'd0;
            BUS_OE   <= 1'b0;
            D_OE     <= 1'b0;
        end else begin
            state    <= state_n;
            we_q     <= we_n;
            byte_q   <= byte_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            err_flag <= err_flag_n;
            RDATA    <= rdata_n;
            DONE     <= done_n;
            ERR      <= err_n;
            BUSY     <= busy_n;
            BR       <= br_n;
            BGACK    <= bgack_n;
            AS       <= as_n;
            UDS      <= uds_n;
            LDS      <= lds_n;
            RW       <= rw_n;
            A_OUT    <= a_out_n;
            D_OUT    <= d_out_n;
            BUS_OE   <= bus_oe_n;
            D_OE     <= d_oe_n;
        end
    end

    // All outputs are registered: each state computes the values seen after its edge.
    always_comb begin
        state_n    = state;
        we_n       = we_q;
        byte_n     = byte_q;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        err_flag_n = err_flag;
        rdata_n    = RDATA;
        done_n     = 1'b0;
        err_n      = 1'b0;
        busy_n     = BUSY;
        br_n       = BR;
        bgack_n    = BGACK;
        as_n       = AS;
        uds_n      = UDS;
        lds_n      = LDS;
        rw_n       = RW;
        a_out_n    = A_OUT;
        d_out_n    = D_OUT;
        bus_oe_n   = BUS_OE;
        d_oe_n     = D_OE;

        case (state)
            IDLE: begin
                if (REQ) begin
                    if (!BYTE && ADDR_IN[0]) begin
                        done_n = 1'b1;
                        err_n  = 1'b1;
                    end else begin
                        we_n       = WE;
                        byte_n     = BYTE;
                        addr_n     = ADDR_IN;
                        wdata_n    = WDATA;
                        err_flag_n = 1'b0;
                        busy_n     = 1'b1;
                        state_n    = BUSREQ;
                    end
                end
            end
            BUSREQ: begin
                br_n    = 1'b0;
                state_n = GRANT_WAIT;
            end
            GRANT_WAIT: begin
                if (!bg_s && as_s && dtack_s) begin
                    bgack_n = 1'b0;
                    br_n    = 1'b1;
                    state_n = DRIVE;
                end
            end
            DRIVE: begin
                bus_oe_n = 1'b1;
                a_out_n  = addr_q[23:1];
                rw_n     = ~we_q;
                if (we_q) begin
                    d_oe_n  = 1'b1;
                    d_out_n = byte_q ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q;
                end
                state_n = STROBE;
            end
            STROBE: begin
                as_n    = 1'b0;
                uds_n   = byte_q && addr_q[0];
                lds_n   = byte_q && !addr_q[0];
                state_n = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!berr_s) begin
                    err_flag_n = 1'b1;
                    state_n    = TERM;
                end else if (!dtack_s) begin
                    if (!we_q) begin
                        if (byte_q)
                            rdata_n = {8'h00, addr_q[0] ? D_IN[7:0] : D_IN[15:8]};
                        else
                            rdata_n = D_IN;
                    end
                    state_n = TERM;
                end else if (tmo_hit) begin
                    err_flag_n = 1'b1;
                    state_n    = TERM;
                end
            end
            TERM: begin
                as_n    = 1'b1;
                uds_n   = 1'b1;
                lds_n   = 1'b1;
                d_oe_n  = 1'b0;
                state_n = RELEASE;
            end
            RELEASE: begin
                if (release_ok) begin
                    bus_oe_n = 1'b0;
                    bgack_n  = 1'b1;
                    rw_n     = 1'b1;
                    done_n   = 1'b1;
                    err_n    = err_flag;
                    busy_n   = 1'b0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_master.sv
`timescale 1ns/1ps
// tb_bus_master: directed checks of arbitration, strobes, error paths and async reset.
module tb_bus_master;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ, WE, BYTE;
    logic [23:0] ADDR_IN;
    logic [15:0] WDATA;
    logic [15:0] RDATA;
    logic        DONE, ERR, BUSY, BR, BGACK;
    logic        BG, AS_IN, DTACK, BERR;
    logic        AS, UDS, LDS, RW;
    logic [22:0] A_OUT;
    logic [15:0] D_OUT;
    logic [15:0] D_IN;
    logic        BUS_OE, D_OE;

    int   checkCount = 0;
    int   errorCount = 0;
    logic stillBusy;

    always #5 CLK = ~CLK;

    bus_master #(.TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .BYTE(BYTE),
        .ADDR_IN(ADDR_IN), .WDATA(WDATA), .RDATA(RDATA), .DONE(DONE),
        .ERR(ERR), .BUSY(BUSY), .BR(BR), .BGACK(BGACK), .BG(BG),
        .AS_IN(AS_IN), .DTACK(DTACK), .BERR(BERR), .AS(AS), .UDS(UDS),
        .LDS(LDS), .RW(RW), .A_OUT(A_OUT), .D_OUT(D_OUT), .D_IN(D_IN),
        .BUS_OE(BUS_OE), .D_OE(D_OE)
    );

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        $display("[TB] reset values: %s", tag);
        checkBit("rst_br", BR, 1'b1);
        checkBit("rst_bgack", BGACK, 1'b1);
        checkBit("rst_as", AS, 1'b1);
        checkBit("rst_uds", UDS, 1'b1);
        checkBit("rst_lds", LDS, 1'b1);
        checkBit("rst_rw", RW, 1'b1);
        checkBit("rst_bus_oe", BUS_OE, 1'b0);
        checkBit("rst_d_oe", D_OE, 1'b0);
        checkBit("rst_done", DONE, 1'b0);
        checkBit("rst_err", ERR, 1'b0);
        checkBit("rst_busy", BUSY, 1'b0);
        checkOutput("rst_rdata", 32'(RDATA), 32'h0);
        checkOutput("rst_a_out", 32'(A_OUT), 32'h0);
        checkOutput("rst_d_out", 32'(D_OUT), 32'h0);
    endtask

    // Issue a request, grant the bus and step until the strobes are asserted.
    task automatic applyStimulus(input logic we, input logic isByte,
                                 input logic [23:0] addr, input logic [15:0] wdata);
        logic [22:0] expAddr;
        logic        expRw, expUds, expLds;
        expAddr = addr[23:1];
        expRw   = !we;
        expUds  = isByte && addr[0];
        expLds  = isByte && !addr[0];
        WE = we; BYTE = isByte; ADDR_IN = addr; WDATA = wdata; REQ = 1'b1;
        tick(1);
        REQ = 1'b0;
        checkBit("busy_on_accept", BUSY, 1'b1);
        checkBit("br_one_cycle", BR, 1'b1);
        tick(1);
        checkBit("br_asserted", BR, 1'b0);
        BG = 1'b0;
        tick(2);
        checkBit("bgack_sync_wait", BGACK, 1'b1);
        tick(1);
        checkBit("bgack_asserted", BGACK, 1'b0);
        checkBit("br_released", BR, 1'b1);
        tick(1);
        checkBit("bus_oe_on", BUS_OE, 1'b1);
        checkBit("as_setup", AS, 1'b1);
        checkOutput("a_out", 32'(A_OUT), 32'(expAddr));
        checkBit("rw_dir", RW, expRw);
        checkBit("d_oe_dir", D_OE, we);
        tick(1);
        checkBit("as_low", AS, 1'b0);
        checkBit("uds_lane", UDS, expUds);
        checkBit("lds_lane", LDS, expLds);
    endtask

    initial begin
        RST = 1'b0; REQ = 1'b0; WE = 1'b0; BYTE = 1'b0; ADDR_IN = 24'h0;
        WDATA = 16'h0; BG = 1'b1; AS_IN = 1'b1; DTACK = 1'b1; BERR = 1'b1;
        D_IN = 16'h0;
        tick(3);
        checkResetValues("power-on");
        RST = 1'b1;
        tick(3);

        $display("[TB] word write 0x800000 <- 0xBEEF");
        applyStimulus(1'b1, 1'b0, 24'h800000, 16'hBEEF);
        checkOutput("d_out_word", 32'(D_OUT), 32'hBEEF);
        tick(2);
        checkBit("as_hold_wait", AS, 1'b0);
        DTACK = 1'b0;
        tick(3);
        checkBit("as_hold_term", AS, 1'b0);
        tick(1);
        checkBit("as_negated", AS, 1'b1);
        checkBit("uds_negated", UDS, 1'b1);
        checkBit("lds_negated", LDS, 1'b1);
        checkBit("d_oe_off", D_OE, 1'b0);
        checkBit("bus_oe_held", BUS_OE, 1'b1);
        DTACK = 1'b1;
        tick(2);
        checkBit("done_waits_dtack", DONE, 1'b0);
        tick(1);
        checkBit("write_done", DONE, 1'b1);
        checkBit("write_err", ERR, 1'b0);
        checkBit("write_bgack_rel", BGACK, 1'b1);
        checkBit("write_bus_oe_off", BUS_OE, 1'b0);
        checkBit("write_busy_clr", BUSY, 1'b0);
        checkBit("write_rw_idle", RW, 1'b1);
        tick(1);
        checkBit("done_one_cycle", DONE, 1'b0);
        BG = 1'b1;
        tick(3);

        $display("[TB] byte read 0xF00003");
        applyStimulus(1'b0, 1'b1, 24'hF00003, 16'h0000);
        D_IN = 16'h12A5;
        DTACK = 1'b0;
        tick(3);
        checkOutput("byte_rdata_latch", 32'(RDATA), 32'h00A5);
        tick(1);
        checkBit("byte_lds_negated", LDS, 1'b1);
        DTACK = 1'b1;
        tick(3);
        checkBit("byte_done", DONE, 1'b1);
        checkBit("byte_err", ERR, 1'b0);
        checkOutput("byte_rdata_done", 32'(RDATA), 32'h00A5);
        tick(1);
        BG = 1'b1;
        tick(3);

        $display("[TB] misaligned word at 0x800001");
        WE = 1'b1; BYTE = 1'b0; ADDR_IN = 24'h800001; REQ = 1'b1;
        tick(1);
        REQ = 1'b0;
        checkBit("misalign_done", DONE, 1'b1);
        checkBit("misalign_err", ERR, 1'b1);
        checkBit("misalign_br", BR, 1'b1);
        checkBit("misalign_busy", BUSY, 1'b0);
        tick(1);
        checkBit("misalign_done_clr", DONE, 1'b0);
        tick(3);
        checkBit("misalign_br_idle", BR, 1'b1);
        checkBit("misalign_bus_oe", BUS_OE, 1'b0);

        $display("[TB] BERR with DTACK during WAIT_ACK");
        applyStimulus(1'b0, 1'b0, 24'h000100, 16'h0000);
        D_IN = 16'h5555;
        BERR = 1'b0;
        DTACK = 1'b0;
        tick(3);
        checkOutput("berr_rdata_kept", 32'(RDATA), 32'h00A5);
        tick(1);
        checkBit("berr_as_negated", AS, 1'b1);
        checkBit("berr_uds_negated", UDS, 1'b1);
        checkBit("berr_lds_negated", LDS, 1'b1);
        checkBit("berr_no_early_done", DONE, 1'b0);
        BERR = 1'b1;
        DTACK = 1'b1;
        tick(3);
        checkBit("berr_done", DONE, 1'b1);
        checkBit("berr_err", ERR, 1'b1);
        checkBit("berr_bus_oe_off", BUS_OE, 1'b0);
        checkBit("berr_bgack_rel", BGACK, 1'b1);
        checkOutput("berr_rdata_final", 32'(RDATA), 32'h00A5);
        tick(1);
        BG = 1'b1;
        tick(3);

`ifdef BUS_TIMEOUT_EN
        $display("[TB] timeout after 16 cycles");
        applyStimulus(1'b1, 1'b0, 24'h000200, 16'h1234);
        tick(15);
        checkBit("tmo_not_early", AS, 1'b0);
        tick(1);
        checkBit("tmo_term_entry", AS, 1'b0);
        tick(1);
        checkBit("tmo_strobes_off", AS, 1'b1);
        tick(1);
        checkBit("tmo_done", DONE, 1'b1);
        checkBit("tmo_err", ERR, 1'b1);
        tick(1);
        BG = 1'b1;
        tick(3);
        applyStimulus(1'b1, 1'b0, 24'h000300, 16'h5678);
        tick(4);
`else
        $display("[TB] no DTACK, no watchdog");
        applyStimulus(1'b1, 1'b0, 24'h000200, 16'h1234);
        stillBusy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (!BUSY) stillBusy = 1'b0;
        end
        checkBit("busy_no_timeout", stillBusy, 1'b1);
        checkBit("as_no_timeout", AS, 1'b0);
`endif

        $display("[TB] asynchronous reset in WAIT_ACK");
        #2;
        RST = 1'b0;
        BG = 1'b1;
        #1;
        checkResetValues("mid-cycle");
        tick(2);
        checkBit("rst_no_done", DONE, 1'b0);
        RST = 1'b1;
        tick(3);
        applyStimulus(1'b0, 1'b0, 24'h000400, 16'h0000);
        D_IN = 16'hCAFE;
        DTACK = 1'b0;
        tick(3);
        checkOutput("post_rst_rdata", 32'(RDATA), 32'hCAFE);
        tick(1);
        DTACK = 1'b1;
        tick(3);
        checkBit("post_rst_done", DONE, 1'b1);
        checkBit("post_rst_err", ERR, 1'b0);
        checkBit("post_rst_busy", BUSY, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
